// File: rtl/vid_pal_sched_if.sv
// Palette scheduler bus: shadow write port, commit commands, vblank pulse,
// registered palette write port and status flags.
interface vid_pal_sched_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic [AW-1:0] shd_addr;
  logic [DW-1:0] shd_data;
  logic          shd_we;
  logic          shd_rdy;
  logic          cmd_commit;
  logic          cmd_now;
  logic          vid_vbl_start;
  logic [AW-1:0] pal_w_addr;
  logic [DW-1:0] pal_w_data;
  logic          pal_w_ena;
  logic          stat_pending;
  logic          stat_busy;
  logic          stat_done;

  modport master (
    output shd_addr, shd_data, shd_we,
    output cmd_commit, cmd_now, vid_vbl_start,
    input  shd_rdy, pal_w_addr, pal_w_data, pal_w_ena,
    input  stat_pending, stat_busy, stat_done
  );

  modport slave (
    input  shd_addr, shd_data, shd_we,
    input  cmd_commit, cmd_now, vid_vbl_start,
    output shd_rdy, pal_w_addr, pal_w_data, pal_w_ena,
    output stat_pending, stat_busy, stat_done
  );
endinterface

// File: rtl/vid_pal_sched.sv
// Shadow palette RAM copied into the live palette on vblank or on demand.
// Ports: clk, rst (sync, active-high), bus (vid_pal_sched_if.slave).
module vid_pal_sched #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input logic clk,
  input logic rst,
  vid_pal_sched_if.slave bus
);
  localparam int N = 1 << AW;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_COPY  = 2'd2;

  logic [1:0]    state;
  logic [AW:0]   idx;
  logic          rearm;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          w_ena;
  logic          done;
  logic          busy;
  logic          last;

  logic [DW-1:0] mem [N];

  // Busy spans COPY plus the trailing registered write cycle.
  assign busy = (state == S_COPY) | w_ena;
  assign last = (idx == (AW+1)'(N - 1));

  assign bus.shd_rdy      = ~busy;
  assign bus.pal_w_addr   = w_addr;
  assign bus.pal_w_data   = w_data;
  assign bus.pal_w_ena    = w_ena;
  assign bus.stat_pending = (state == S_ARMED);
  assign bus.stat_busy    = busy;
  assign bus.stat_done    = done;

  always_ff @(posedge clk) begin
    if (!rst && bus.shd_we && !busy)
      mem[bus.shd_addr] <= bus.shd_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      idx    <= '0;
      rearm  <= 1'b0;
      w_addr <= '0;
      w_data <= '0;
      w_ena  <= 1'b0;
      done   <= 1'b0;
    end else begin
      // The RAM read register doubles as the palette write data register.
      w_ena <= (state == S_COPY);
      if (state == S_COPY) begin
        w_addr <= idx[AW-1:0];
        w_data <= mem[idx[AW-1:0]];
      end
      done <= w_ena && (w_addr == {AW{1'b1}});

      unique case (state)
        S_IDLE: begin
          if (bus.cmd_now) begin
            state <= S_COPY;
            idx   <= '0;
          end else if (bus.cmd_commit) begin
            state <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (bus.vid_vbl_start || bus.cmd_now) begin
            state <= S_COPY;
            idx   <= '0;
          end
        end
        S_COPY: begin
          idx <= idx + 1'b1;
          if (bus.cmd_commit || bus.cmd_now)
            rearm <= 1'b1;
          if (last) begin
            idx   <= '0;
            rearm <= 1'b0;
            if (rearm || bus.cmd_commit || bus.cmd_now)
              state <= S_ARMED;
            else
              state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          idx   <= '0;
          rearm <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vid_pal_sched.sv
// Directed bench for vid_pal_sched with a write scoreboard.
// Expected palette writes (addr, data, cycle) are queued at stimulus time.
module tb_vid_pal_sched;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int N  = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [31:0]   c;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  bit   mon_on = 1'b0;
  wr_t  q[$];
  logic [DW-1:0] model [N];

  vid_pal_sched_if #(.AW(AW), .DW(DW)) bus ();

  vid_pal_sched #(.AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on && bus.pal_w_ena === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_write", {bus.pal_w_addr, bus.pal_w_data}, 64'h0);
      end else begin
        wr_t e;
        wr_t g;
        e = q.pop_front();
        g = '{a: bus.pal_w_addr, d: bus.pal_w_data, c: 32'(cyc)};
        chk("pal_write", 64'(g), 64'(e));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  task automatic push_copy(input int t, input int lo, input int hi);
    for (int i = lo; i <= hi; i++)
      q.push_back('{a: AW'(i), d: model[i], c: 32'(t + 2 + i)});
  endtask

  task automatic wait_done(input int t, output logic pend);
    pend = 1'b0;
    while (cyc < t + N + 2) begin
      @(negedge clk);
      pend |= bus.stat_pending;
      if (cyc == t + N + 1)
        chk("done_busy_last_write", {bus.stat_done, bus.stat_busy}, 64'b01);
    end
    chk("done_pulse", {bus.stat_done, bus.stat_busy}, 64'b10);
    chk("queue_drained", 64'(q.size()), 64'd0);
    step();
    chk("done_one_cycle", 64'(bus.stat_done), 64'd0);
  endtask

  initial begin
    int  t;
    int  bad;
    logic pend;
    bus.shd_addr = '0;
    bus.shd_data = '0;
    bus.shd_we = 1'b0;
    bus.cmd_commit = 1'b0;
    bus.cmd_now = 1'b0;
    bus.vid_vbl_start = 1'b0;

    step();
    step();
    rst = 1'b0;
    mon_on = 1'b1;
    @(negedge clk);
    chk("reset_outputs",
        {bus.pal_w_ena, bus.pal_w_addr, bus.pal_w_data,
         bus.stat_pending, bus.stat_busy, bus.stat_done, bus.shd_rdy},
        64'b1);
    step();

    // Fill shadow with A500+i
    for (int i = 0; i < N; i++) begin
      bus.shd_addr = AW'(i);
      bus.shd_data = 16'hA500 + 16'(i);
      bus.shd_we = 1'b1;
      model[i] = 16'hA500 + 16'(i);
      step();
    end
    bus.shd_we = 1'b0;

    // Commit, then vblank later
    bus.cmd_commit = 1'b1;
    step();
    bus.cmd_commit = 1'b0;
    @(negedge clk);
    chk("armed_pending", 64'(bus.stat_pending), 64'd1);
    step();
    repeat (20) step();
    t = cyc;
    bus.vid_vbl_start = 1'b1;
    push_copy(t, 0, N - 1);
    step();
    bus.vid_vbl_start = 1'b0;
    @(negedge clk);
    chk("busy_on_entry", {bus.stat_busy, bus.shd_rdy}, 64'b10);
    wait_done(t, pend);
    chk("idle_after_copy", 64'(bus.stat_pending), 64'd0);

    // Long wait armed with no vblank
    bus.cmd_commit = 1'b1;
    step();
    bus.cmd_commit = 1'b0;
    bad = 0;
    repeat (10000) begin
      @(negedge clk);
      if (bus.stat_pending !== 1'b1) bad++;
      step();
    end
    chk("pending_held", 64'(bad), 64'd0);

    // cmd_now while armed
    t = cyc;
    bus.cmd_now = 1'b1;
    push_copy(t, 0, N - 1);
    step();
    bus.cmd_now = 1'b0;
    wait_done(t, pend);
    chk("armed_now_no_rearm", 64'(bus.stat_pending), 64'd0);

    // cmd_now from idle, commit during copy re-arms
    t = cyc;
    bus.cmd_now = 1'b1;
    push_copy(t, 0, N - 1);
    step();
    bus.cmd_now = 1'b0;
    goto(t + 50);
    bus.cmd_commit = 1'b1;
    step();
    bus.cmd_commit = 1'b0;
    wait_done(t, pend);
    chk("rearmed_after_copy", 64'(bus.stat_pending), 64'd1);
    t = cyc;
    bus.vid_vbl_start = 1'b1;
    push_copy(t, 0, N - 1);
    step();
    bus.vid_vbl_start = 1'b0;
    wait_done(t, pend);

    // vblank in idle does nothing
    bus.vid_vbl_start = 1'b1;
    step();
    bus.vid_vbl_start = 1'b0;
    repeat (5) step();
    @(negedge clk);
    chk("vbl_idle_ignored", {bus.stat_pending, bus.stat_busy}, 64'b0);
    step();

    // Shadow write held across a copy
    t = cyc;
    bus.cmd_now = 1'b1;
    push_copy(t, 0, N - 1);
    step();
    bus.cmd_now = 1'b0;
    goto(t + 10);
    bus.shd_addr = 8'd5;
    bus.shd_data = 16'h1234;
    bus.shd_we = 1'b1;
    bad = 0;
    while (cyc < t + N + 2) begin
      @(negedge clk);
      if (bus.shd_rdy !== (cyc >= t + N + 2)) bad++;
    end
    chk("rdy_blocked_in_copy", 64'(bad), 64'd0);
    chk("rdy_after_copy", 64'(bus.shd_rdy), 64'd1);
    step();
    bus.shd_we = 1'b0;
    model[5] = 16'h1234;
    t = cyc;
    bus.cmd_now = 1'b1;
    push_copy(t, 0, N - 1);
    step();
    bus.cmd_now = 1'b0;
    wait_done(t, pend);

    // Reset mid-copy at write index 100; commit during reset ignored
    t = cyc;
    bus.cmd_now = 1'b1;
    push_copy(t, 0, 100);
    step();
    bus.cmd_now = 1'b0;
    goto(t + 102);
    rst = 1'b1;
    bus.cmd_commit = 1'b1;
    step();
    rst = 1'b0;
    bus.cmd_commit = 1'b0;
    @(negedge clk);
    chk("abort_outputs",
        {bus.pal_w_ena, bus.stat_pending, bus.stat_busy, bus.stat_done},
        64'b0);
    chk("abort_queue", 64'(q.size()), 64'd0);
    step();
    t = cyc;
    bus.cmd_now = 1'b1;
    push_copy(t, 0, N - 1);
    step();
    bus.cmd_now = 1'b0;
    wait_done(t, pend);

    // commit and now together: one copy, never pending
    t = cyc;
    bus.cmd_commit = 1'b1;
    bus.cmd_now = 1'b1;
    push_copy(t, 0, N - 1);
    step();
    bus.cmd_commit = 1'b0;
    bus.cmd_now = 1'b0;
    wait_done(t, pend);
    chk("both_no_pending", 64'(pend), 64'd0);
    repeat (20) step();
    @(negedge clk);
    chk("both_single_copy",
        {32'(q.size()), 31'd0, bus.stat_pending}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
